// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS control path.
// State encodings are visible on the debug state port.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXECUTE = 4'd6,
    ALUWB   = 4'd7,
    BEQEX   = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JEX     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // ready_gated marks states whose pc_write/ir_write/instr_done wait on memory.
  typedef struct packed {
    logic       pc_write;
    logic       branch;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       instr_done;
    logic       ready_gated;
  } ctrl_t;

endpackage

// File: rtl/multicycle_control_decode.sv
// Moore output decode: maps the current state to the raw control vector.
import mips_ctrl_pkg::*;

module multicycle_control_decode (
  input  state_t state,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      FETCH: begin
        ctrl.mem_read    = 1'b1;
        ctrl.ir_write    = 1'b1;
        ctrl.pc_write    = 1'b1;
        ctrl.alu_src_b   = SRCB_FOUR;
        ctrl.alu_op      = ALUOP_ADD;
        ctrl.pc_src      = PCSRC_ALU;
        ctrl.ready_gated = 1'b1;
      end
      DECODE: begin
        ctrl.alu_src_b = SRCB_IMMSH;
        ctrl.alu_op    = ALUOP_ADD;
      end
      MEMADR, ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      MEMRD: begin
        ctrl.iord     = 1'b1;
        ctrl.mem_read = 1'b1;
      end
      MEMWB: begin
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      MEMWR: begin
        ctrl.iord        = 1'b1;
        ctrl.mem_write   = 1'b1;
        ctrl.instr_done  = 1'b1;
        ctrl.ready_gated = 1'b1;
      end
      EXECUTE: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      ALUWB: begin
        ctrl.reg_dst    = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      BEQEX: begin
        ctrl.alu_src_a  = 1'b1;
        ctrl.alu_src_b  = SRCB_REG;
        ctrl.alu_op     = ALUOP_SUB;
        ctrl.pc_src     = PCSRC_ALUOUT;
        ctrl.branch     = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      ADDIWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      JEX: begin
        ctrl.pc_src     = PCSRC_JUMP;
        ctrl.pc_write   = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS main control FSM: state register, sequencing, memory-ready
// qualification, reset gating of all outputs and the sticky illegal-opcode flag.
import mips_ctrl_pkg::*;

module multicycle_control #(
  parameter bit ENABLE_JUMP = 1'b1,
  parameter bit MEM_WAIT    = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       branch,
  output logic       pc_en,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_src,
  output logic       instr_done,
  output logic       illegal_op,
  output logic [3:0] state
);

  state_t state_q;
  state_t state_d;
  logic   illegal_d;
  ctrl_t  ctrl;
  logic   rdy;
  logic   qual;
  logic   active;

  assign rdy = MEM_WAIT ? mem_ready : 1'b1;

  always_comb begin
    state_d   = FETCH;
    illegal_d = 1'b0;
    case (state_q)
      FETCH:  state_d = rdy ? DECODE : FETCH;
      DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = EXECUTE;
          OP_BEQ:       state_d = BEQEX;
          OP_ADDI:      state_d = ADDIEX;
          OP_J: begin
            if (ENABLE_JUMP) state_d = JEX;
            else             illegal_d = 1'b1;
          end
          default:      illegal_d = 1'b1;
        endcase
      end
      MEMADR:  state_d = (opcode == OP_SW) ? MEMWR : MEMRD;
      MEMRD:   state_d = rdy ? MEMWB : MEMRD;
      MEMWR:   state_d = rdy ? FETCH : MEMWR;
      EXECUTE: state_d = ALUWB;
      ADDIEX:  state_d = ADDIWB;
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= FETCH;
      illegal_op <= 1'b0;
    end else begin
      state_q <= state_d;
      if (illegal_d) illegal_op <= 1'b1;
    end
  end

  multicycle_control_decode u_decode (
    .state (state_q),
    .ctrl  (ctrl)
  );

  // Reset gates everything combinationally so a mid-instruction abort writes nothing.
  assign active = ~reset;
  assign qual   = ~ctrl.ready_gated | rdy;

  assign pc_write   = active & ctrl.pc_write & qual;
  assign ir_write   = active & ctrl.ir_write & qual;
  assign instr_done = active & ctrl.instr_done & qual;
  assign branch     = active & ctrl.branch;
  assign iord       = active & ctrl.iord;
  assign mem_read   = active & ctrl.mem_read;
  assign mem_write  = active & ctrl.mem_write;
  assign reg_dst    = active & ctrl.reg_dst;
  assign mem_to_reg = active & ctrl.mem_to_reg;
  assign reg_write  = active & ctrl.reg_write;
  assign alu_src_a  = active & ctrl.alu_src_a;
  assign alu_src_b  = {2{active}} & ctrl.alu_src_b;
  assign alu_op     = {2{active}} & ctrl.alu_op;
  assign pc_src     = {2{active}} & ctrl.pc_src;
  assign pc_en      = pc_write | (branch & zero);
  assign state      = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: expected output vectors are queued by the
// driver and compared on the falling edge by an independent monitor.
module tb_multicycle_control;

  typedef struct packed {
    logic [3:0] state;
    logic       pc_write;
    logic       branch;
    logic       pc_en;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       instr_done;
    logic       illegal_op;
  } obs_t;

  localparam int W = $bits(obs_t);

  localparam logic [5:0] LW   = 6'b100011;
  localparam logic [5:0] SW   = 6'b101011;
  localparam logic [5:0] RT   = 6'b000000;
  localparam logic [5:0] BEQ  = 6'b000100;
  localparam logic [5:0] ADDI = 6'b001000;
  localparam logic [5:0] JMP  = 6'b000010;
  localparam logic [5:0] BAD  = 6'b111111;

  logic       clk;
  logic       reset;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;

  logic       m_pc_write, m_branch, m_pc_en, m_iord, m_mem_read, m_mem_write, m_ir_write;
  logic       m_reg_dst, m_mem_to_reg, m_reg_write, m_alu_src_a, m_instr_done, m_illegal_op;
  logic [1:0] m_alu_src_b, m_alu_op, m_pc_src;
  logic [3:0] m_state;

  logic       n_pc_write, n_branch, n_pc_en, n_iord, n_mem_read, n_mem_write, n_ir_write;
  logic       n_reg_dst, n_mem_to_reg, n_reg_write, n_alu_src_a, n_instr_done, n_illegal_op;
  logic [1:0] n_alu_src_b, n_alu_op, n_pc_src;
  logic [3:0] n_state;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_nj_q[$];
  obs_t m_obs, n_obs, m_exp, n_exp;
  int tests_run = 0;
  int failed    = 0;
  int step_m    = 0;
  int step_n    = 0;

  multicycle_control dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_write(m_pc_write), .branch(m_branch), .pc_en(m_pc_en), .iord(m_iord),
    .mem_read(m_mem_read), .mem_write(m_mem_write), .ir_write(m_ir_write),
    .reg_dst(m_reg_dst), .mem_to_reg(m_mem_to_reg), .reg_write(m_reg_write),
    .alu_src_a(m_alu_src_a), .alu_src_b(m_alu_src_b), .alu_op(m_alu_op),
    .pc_src(m_pc_src), .instr_done(m_instr_done), .illegal_op(m_illegal_op),
    .state(m_state)
  );

  multicycle_control #(.ENABLE_JUMP(1'b0)) dut_nj (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_write(n_pc_write), .branch(n_branch), .pc_en(n_pc_en), .iord(n_iord),
    .mem_read(n_mem_read), .mem_write(n_mem_write), .ir_write(n_ir_write),
    .reg_dst(n_reg_dst), .mem_to_reg(n_mem_to_reg), .reg_write(n_reg_write),
    .alu_src_a(n_alu_src_a), .alu_src_b(n_alu_src_b), .alu_op(n_alu_op),
    .pc_src(n_pc_src), .instr_done(n_instr_done), .illegal_op(n_illegal_op),
    .state(n_state)
  );

  assign m_obs = {m_state, m_pc_write, m_branch, m_pc_en, m_iord, m_mem_read, m_mem_write,
                  m_ir_write, m_reg_dst, m_mem_to_reg, m_reg_write, m_alu_src_a,
                  m_alu_src_b, m_alu_op, m_pc_src, m_instr_done, m_illegal_op};
  assign n_obs = {n_state, n_pc_write, n_branch, n_pc_en, n_iord, n_mem_read, n_mem_write,
                  n_ir_write, n_reg_dst, n_mem_to_reg, n_reg_write, n_alu_src_a,
                  n_alu_src_b, n_alu_op, n_pc_src, n_instr_done, n_illegal_op};

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected outputs for a state outside reset, written from the state table.
  function automatic obs_t ev(input int s, input logic rdy, input logic z, input logic ill);
    obs_t o;
    o = '0;
    o.state      = 4'(s);
    o.illegal_op = ill;
    case (s)
      0:  begin o.mem_read = 1'b1; o.alu_src_b = 2'b01;
                o.ir_write = rdy; o.pc_write = rdy; o.pc_en = rdy; end
      1:  o.alu_src_b = 2'b11;
      2:  begin o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; end
      3:  begin o.iord = 1'b1; o.mem_read = 1'b1; end
      4:  begin o.mem_to_reg = 1'b1; o.reg_write = 1'b1; o.instr_done = 1'b1; end
      5:  begin o.iord = 1'b1; o.mem_write = 1'b1; o.instr_done = rdy; end
      6:  begin o.alu_src_a = 1'b1; o.alu_op = 2'b10; end
      7:  begin o.reg_dst = 1'b1; o.reg_write = 1'b1; o.instr_done = 1'b1; end
      8:  begin o.alu_src_a = 1'b1; o.alu_op = 2'b01; o.pc_src = 2'b01;
                o.branch = 1'b1; o.instr_done = 1'b1; o.pc_en = z; end
      9:  begin o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; end
      10: begin o.reg_write = 1'b1; o.instr_done = 1'b1; end
      11: begin o.pc_src = 2'b10; o.pc_write = 1'b1; o.pc_en = 1'b1; o.instr_done = 1'b1; end
      default: o = '0;
    endcase
    return o;
  endfunction

  // Expected outputs while reset is high: only state and the sticky flag show through.
  function automatic obs_t rv(input int s, input logic ill);
    obs_t o;
    o = '0;
    o.state      = 4'(s);
    o.illegal_op = ill;
    return o;
  endfunction

  // Driver tasks
  task automatic cyc2(input logic rst, input logic [5:0] op, input logic z, input logic rdy,
                      input obs_t e, input obs_t e_nj);
    reset     = rst;
    opcode    = op;
    zero      = z;
    mem_ready = rdy;
    exp_q.push_back(e);
    exp_nj_q.push_back(e_nj);
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic rst, input logic [5:0] op, input logic z, input logic rdy,
                     input obs_t e);
    cyc2(rst, op, z, rdy, e, e);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      m_exp = exp_q.pop_front();
      tests_run++;
      if (m_obs !== m_exp) begin
        failed++;
        $display("FAIL main step %0d: got %h expected %h", step_m, m_obs, m_exp);
      end
      step_m++;
    end
    if (exp_nj_q.size() != 0) begin
      n_exp = exp_nj_q.pop_front();
      tests_run++;
      if (n_obs !== n_exp) begin
        failed++;
        $display("FAIL nojump step %0d: got %h expected %h", step_n, n_obs, n_exp);
      end
      step_n++;
    end
  end

  initial begin
    reset     = 1'b1;
    opcode    = LW;
    zero      = 1'b0;
    mem_ready = 1'b1;
    @(posedge clk);
    #1;
    cyc(1, LW, 0, 1, rv(0, 0));
    cyc(1, LW, 0, 1, rv(0, 0));

    // lw: 0,1,2,3,4
    cyc(0, LW, 0, 1, ev(0, 1, 0, 0));
    cyc(0, LW, 0, 1, ev(1, 1, 0, 0));
    cyc(0, LW, 0, 1, ev(2, 1, 0, 0));
    cyc(0, LW, 0, 1, ev(3, 1, 0, 0));
    cyc(0, LW, 0, 1, ev(4, 1, 0, 0));

    // sw with three wait cycles in MEMWR
    cyc(0, SW, 0, 1, ev(0, 1, 0, 0));
    cyc(0, SW, 0, 1, ev(1, 1, 0, 0));
    cyc(0, SW, 0, 1, ev(2, 1, 0, 0));
    for (int i = 0; i < 3; i++) cyc(0, SW, 0, 0, ev(5, 0, 0, 0));
    cyc(0, SW, 0, 1, ev(5, 1, 0, 0));

    // R-type with one fetch wait cycle
    cyc(0, RT, 0, 0, ev(0, 0, 0, 0));
    cyc(0, RT, 0, 1, ev(0, 1, 0, 0));
    cyc(0, RT, 0, 1, ev(1, 1, 0, 0));
    cyc(0, RT, 0, 1, ev(6, 1, 0, 0));
    cyc(0, RT, 0, 1, ev(7, 1, 0, 0));

    // addi
    cyc(0, ADDI, 0, 1, ev(0, 1, 0, 0));
    cyc(0, ADDI, 0, 1, ev(1, 1, 0, 0));
    cyc(0, ADDI, 0, 1, ev(9, 1, 0, 0));
    cyc(0, ADDI, 0, 1, ev(10, 1, 0, 0));

    // beq taken, then not taken
    cyc(0, BEQ, 1, 1, ev(0, 1, 1, 0));
    cyc(0, BEQ, 1, 1, ev(1, 1, 1, 0));
    cyc(0, BEQ, 1, 1, ev(8, 1, 1, 0));
    cyc(0, BEQ, 0, 1, ev(0, 1, 0, 0));
    cyc(0, BEQ, 0, 1, ev(1, 1, 0, 0));
    cyc(0, BEQ, 0, 1, ev(8, 1, 0, 0));

    // illegal opcode, sticky flag survives the following addi
    cyc(0, BAD, 0, 1, ev(0, 1, 0, 0));
    cyc(0, BAD, 0, 1, ev(1, 1, 0, 0));
    cyc(0, ADDI, 0, 1, ev(0, 1, 0, 1));
    cyc(0, ADDI, 0, 1, ev(1, 1, 0, 1));
    cyc(0, ADDI, 0, 1, ev(9, 1, 0, 1));

    // reset during ADDIWB aborts the write-back and clears the flag
    cyc(1, ADDI, 0, 1, rv(10, 1));
    cyc(1, ADDI, 0, 1, rv(0, 0));

    // j: JEX on the default build, illegal on the no-jump build
    cyc2(0, JMP, 0, 1, ev(0, 1, 0, 0), ev(0, 1, 0, 0));
    cyc2(0, JMP, 0, 1, ev(1, 1, 0, 0), ev(1, 1, 0, 0));
    cyc2(0, JMP, 0, 1, ev(11, 1, 0, 0), ev(0, 1, 0, 1));

    // bounded drain of the scoreboard
    for (int i = 0; i < 4 && (exp_q.size() != 0 || exp_nj_q.size() != 0); i++) @(posedge clk);
    #1;
    if (exp_q.size() != 0 || exp_nj_q.size() != 0) begin
      failed++;
      $display("FAIL drain: got %0d entries left, expected 0", exp_q.size() + exp_nj_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
